// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter.
// Supports stall hold, branch/jump redirect, trap vectoring, and misaligned-target
// detection. A one-entry buffer keeps a redirect that arrives during a stall so it is
// applied once the stall is released.
//
// Ports
//   clk_i          clock; all state updates on the rising edge
//   rst_i          synchronous, active-high reset
//   stall_i        hold pc this cycle
//   redirect_i     load target_i (taken branch / jump)
//   target_i       redirect destination
//   trap_i         exception request; highest priority below reset
//   pc_o           current fetch address (registered)
//   pc_plus_o      pc_o + STEP, combinational, wraps mod 2^WIDTH
//   fetch_valid_o  registered; pc_o is a real fetch address
//   pending_o      registered; a buffered redirect is waiting for the stall to release
//   misalign_o     registered one-cycle pulse: a misaligned redirect was turned into a trap
//
// state | meaning
// ------+----------------------------------------------------------
// BOOT  | just out of reset; the first fetch at the reset vector is pending
// RUN   | fetching normally
// HELD  | stalled, no buffered redirect
// PEND  | stalled, buffered redirect valid
module pc_unit #(
    parameter int unsigned            WIDTH        = 32,
    parameter logic [WIDTH-1:0]       RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]       TRAP_VECTOR  = WIDTH'('h80),
    parameter int unsigned            STEP         = 4,
    parameter int unsigned            ALIGN_BITS   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic             trap_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus_o,
    output logic             fetch_valid_o,
    output logic             pending_o,
    output logic             misalign_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HELD = 2'd2,
        PEND = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             fv_q, fv_d;
    logic             mis_q, mis_d;
    logic             tgt_mis;

    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign tgt_mis = |target_i[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign tgt_mis = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        fv_d    = fv_q;
        mis_d   = 1'b0;
        case (state_q)
            BOOT: begin
                // First fetch is the reset vector itself; all requests are ignored here.
                state_d = RUN;
                fv_d    = 1'b1;
            end
            default: begin
                if (trap_i) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = RUN;
                end else if (redirect_i && tgt_mis) begin
                    pc_d    = TRAP_VECTOR;
                    mis_d   = 1'b1;
                    state_d = RUN;
                end else if (redirect_i && !stall_i) begin
                    // A live redirect supersedes anything still buffered.
                    pc_d    = target_i;
                    state_d = RUN;
                end else if (redirect_i) begin
                    buf_d   = target_i;
                    state_d = PEND;
                end else if (!stall_i && state_q == PEND) begin
                    pc_d    = buf_q;
                    state_d = RUN;
                end else if (!stall_i) begin
                    pc_d    = pc_q + STEP_W;
                    state_d = RUN;
                end else begin
                    state_d = (state_q == PEND) ? PEND : HELD;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            buf_q   <= '0;
            fv_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            fv_q    <= fv_d;
            mis_q   <= mis_d;
        end
    end

    assign pc_o          = pc_q;
    assign pc_plus_o     = pc_q + STEP_W;
    assign fetch_valid_o = fv_q;
    assign pending_o     = (state_q == PEND);
    assign misalign_o    = mis_q;

endmodule
